// File: rtl/qs_egress.sv
// Egress stage: reads a committed sorted bank out of the SRAM in address order and streams it
// over valid/ready through a 2-entry buffer that absorbs the 1-cycle SRAM read latency.
module qs_egress #(
  parameter int unsigned W  = 32,
  parameter int unsigned N  = 16,
  localparam int unsigned AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          bank_vld,
  input  logic [AW:0]   bank_n,
  output logic          bank_rdy,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [W-1:0]  rd_data,
  output logic          out_vld,
  output logic [W-1:0]  out_dat,
  output logic          out_last,
  input  logic          out_rdy,
  output logic          bank_done,
  output logic          busy
);

  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

  state_e          state_q, state_d;
  logic [AW:0]     n_q, n_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [AW-1:0]   rd_addr_q, rd_addr_d;
  logic            inflight_q, inflight_d;
  logic            inflight_last_q, inflight_last_d;
  logic [1:0]      occ_q, occ_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic [W-1:0]    buf_dat_q [2];
  logic [W-1:0]    buf_dat_d [2];
  logic [1:0]      buf_last_q, buf_last_d;

  logic            push, pop, issue_last;
  logic [2:0]      level;

  always_comb begin
    pop        = (occ_q != 2'd0) && out_rdy;
    push       = inflight_q;
    issue_last = ({1'b0, addr_q} == (n_q - CW'(1)));
    // Occupancy the buffer would reach if nothing else happened, counting the read in flight.
    level      = 3'(occ_q) + 3'(inflight_q);
    rd_en      = (state_q == StRead) && (level < (3'd2 + 3'(pop)));

    state_d         = state_q;
    n_d             = n_q;
    addr_d          = addr_q;
    inflight_d      = rd_en;
    inflight_last_d = rd_en && issue_last;
    rd_addr         = rd_en ? addr_q : rd_addr_q;
    rd_addr_d       = rd_addr;

    occ_d      = 2'(occ_q + 2'(push) - 2'(pop));
    wr_ptr_d   = push ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d   = pop ? ~rd_ptr_q : rd_ptr_q;
    buf_dat_d  = buf_dat_q;
    buf_last_d = buf_last_q;
    if (push) begin
      buf_dat_d[wr_ptr_q]  = rd_data;
      buf_last_d[wr_ptr_q] = inflight_last_q;
    end

    unique case (state_q)
      StIdle: begin
        if (bank_vld) begin
          n_d     = bank_n;
          addr_d  = '0;
          state_d = (bank_n == '0) ? StDone : StRead;
        end
      end
      StRead: begin
        if (rd_en) begin
          addr_d = addr_q + AW'(1);
          if (issue_last) state_d = StDrain;
        end
      end
      StDrain: begin
        // Leave as the final element pops so bank_done lands in the following cycle.
        if (occ_d == 2'd0 && !inflight_q) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      n_q             <= '0;
      addr_q          <= '0;
      rd_addr_q       <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      occ_q           <= 2'd0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      buf_last_q      <= 2'b00;
    end else begin
      assert (!(push && !pop && occ_q == 2'd2))
        else $error("qs_egress: output buffer overflow");
      state_q         <= state_d;
      n_q             <= n_d;
      addr_q          <= addr_d;
      rd_addr_q       <= rd_addr_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      occ_q           <= occ_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      buf_last_q      <= buf_last_d;
    end
  end

  always_ff @(posedge clk) begin
    buf_dat_q <= buf_dat_d;
  end

  always_comb begin
    out_vld   = (occ_q != 2'd0);
    out_dat   = buf_dat_q[rd_ptr_q];
    out_last  = out_vld && buf_last_q[rd_ptr_q];
    bank_rdy  = (state_q == StIdle);
    busy      = (state_q != StIdle);
    bank_done = (state_q == StDone);
  end

endmodule

// File: tb/tb_qs_egress.sv
// Directed bench for qs_egress: behavioural 1-cycle SRAM, pop/read monitor, per-cycle checks.
module tb_qs_egress;
  localparam int unsigned W  = 32;
  localparam int unsigned N  = 16;
  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          bank_vld = 1'b0;
  logic [AW:0]   bank_n = '0;
  logic          bank_rdy;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data = '0;
  logic          out_vld;
  logic [W-1:0]  out_dat;
  logic          out_last;
  logic          out_rdy = 1'b0;
  logic          bank_done;
  logic          busy;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] mem [N];
  logic [W-1:0] pop_dat [$];
  logic         pop_last [$];
  int           rd_cnt = 0;
  int           done_cnt = 0;

  qs_egress #(.W(W), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bank_vld  (bank_vld),
    .bank_n    (bank_n),
    .bank_rdy  (bank_rdy),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_vld   (out_vld),
    .out_dat   (out_dat),
    .out_last  (out_last),
    .out_rdy   (out_rdy),
    .bank_done (bank_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // SRAM: data valid exactly one cycle after the strobe, junk otherwise.
  always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : 32'hDEAD_BEEF;

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_vld && out_rdy) begin
        pop_dat.push_back(out_dat);
        pop_last.push_back(out_last);
      end
      if (rd_en) rd_cnt++;
      if (bank_done) done_cnt++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic clear_logs();
    pop_dat.delete();
    pop_last.delete();
    rd_cnt   = 0;
    done_cnt = 0;
  endtask

  task automatic wait_done(input string tag, input int lim);
    int k;
    k = 0;
    while (bank_done !== 1'b1 && k < lim) begin
      step();
      k++;
    end
    chk(tag, 32'(bank_done), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_bank_rdy"},  32'(bank_rdy),  32'd1);
    chk({tag, "_rd_en"},     32'(rd_en),     32'd0);
    chk({tag, "_rd_addr"},   32'(rd_addr),   32'd0);
    chk({tag, "_out_vld"},   32'(out_vld),   32'd0);
    chk({tag, "_out_last"},  32'(out_last),  32'd0);
    chk({tag, "_bank_done"}, 32'(bank_done), 32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
  endtask

  initial begin
    logic [W-1:0] e1 [4];
    logic [W-1:0] prev_dat;
    logic         prev_stall;
    logic         got_done;
    e1 = '{32'd3, 32'd7, 32'd9, 32'd12};
    for (int i = 0; i < int'(N); i++) mem[i] = '0;

    // Reset
    out_rdy = 1'b1;
    step();
    step();
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    step();

    // n=4, data {3,7,9,12}, out_rdy high
    for (int i = 0; i < 4; i++) mem[i] = e1[i];
    clear_logs();
    bank_vld = 1'b1;
    bank_n   = 5'd4;
    #1;
    chk("t1_accept_rdy", 32'(bank_rdy), 32'd1);
    step();                                          // T+1
    bank_vld = 1'b0;
    #1;
    chk("t1_rd_en_t1", 32'(rd_en), 32'd1);
    chk("t1_rd_addr_t1", 32'(rd_addr), 32'd0);
    chk("t1_out_vld_t1", 32'(out_vld), 32'd0);
    step();                                          // T+2
    chk("t1_rd_addr_t2", 32'(rd_addr), 32'd1);
    chk("t1_out_vld_t2", 32'(out_vld), 32'd0);
    for (int k = 0; k < 4; k++) begin                // T+3..T+6
      step();
      chk("t1_out_vld", 32'(out_vld), 32'd1);
      chk("t1_out_dat", out_dat, e1[k]);
      chk("t1_out_last", 32'(out_last), (k == 3) ? 32'd1 : 32'd0);
      if (k == 2) chk("t1_rd_en_drain", 32'(rd_en), 32'd0);
    end
    step();                                          // T+7
    chk("t1_bank_done", 32'(bank_done), 32'd1);
    chk("t1_out_vld_t7", 32'(out_vld), 32'd0);
    step();                                          // T+8
    chk("t1_done_pulse", 32'(bank_done), 32'd0);
    chk("t1_bank_rdy_t8", 32'(bank_rdy), 32'd1);
    chk("t1_rd_cnt", 32'(rd_cnt), 32'd4);

    // n=0 then an immediate n=1 bank
    clear_logs();
    bank_vld = 1'b1;
    bank_n   = 5'd0;
    #1;
    step();                                          // T+1
    bank_vld = 1'b0;
    #1;
    chk("t2_bank_done_t1", 32'(bank_done), 32'd1);
    chk("t2_rd_en_t1", 32'(rd_en), 32'd0);
    chk("t2_out_vld_t1", 32'(out_vld), 32'd0);
    step();                                          // T+2
    chk("t2_bank_rdy_t2", 32'(bank_rdy), 32'd1);
    chk("t2_no_reads", 32'(rd_cnt), 32'd0);
    chk("t2_no_pops", 32'(pop_dat.size()), 32'd0);
    mem[0]   = 32'h55;
    bank_vld = 1'b1;
    bank_n   = 5'd1;
    #1;
    step();
    bank_vld = 1'b0;
    #1;
    chk("t2_second_busy", 32'(busy), 32'd1);
    chk("t2_second_rd_en", 32'(rd_en), 32'd1);
    wait_done("t2_second_done", 10);
    step();
    chk("t2_pop_cnt", 32'(pop_dat.size()), 32'd1);
    if (pop_dat.size() == 1) begin
      chk("t2_pop_dat", pop_dat[0], 32'h55);
      chk("t2_pop_last", 32'(pop_last[0]), 32'd1);
    end

    // n=N with out_rdy toggling
    clear_logs();
    for (int i = 0; i < int'(N); i++) mem[i] = 32'h1000 + 32'(i) * 32'h111;
    bank_vld = 1'b1;
    bank_n   = 5'd16;
    #1;
    step();
    bank_vld   = 1'b0;
    prev_stall = 1'b0;
    prev_dat   = '0;
    got_done   = 1'b0;
    for (int k = 0; k < 200 && !got_done; k++) begin
      out_rdy = (k % 2 == 0);
      #1;
      if (prev_stall) begin
        chk("t3_stall_vld", 32'(out_vld), 32'd1);
        chk("t3_stall_dat", out_dat, prev_dat);
      end
      prev_stall = out_vld && !out_rdy;
      prev_dat   = out_dat;
      if (bank_done) got_done = 1'b1;
      else step();
    end
    chk("t3_done_seen", 32'(got_done), 32'd1);
    out_rdy = 1'b1;
    step();
    step();
    chk("t3_rd_cnt", 32'(rd_cnt), 32'd16);
    chk("t3_pop_cnt", 32'(pop_dat.size()), 32'd16);
    for (int i = 0; i < int'(N); i++) begin
      if (pop_dat.size() > i) begin
        chk("t3_pop_dat", pop_dat[i], 32'h1000 + 32'(i) * 32'h111);
        chk("t3_pop_last", 32'(pop_last[i]), (i == 15) ? 32'd1 : 32'd0);
      end
    end

    // n=3 with downstream stalled until T+13
    clear_logs();
    mem[0]   = 32'h50;
    mem[1]   = 32'h60;
    mem[2]   = 32'h80;
    out_rdy  = 1'b0;
    bank_vld = 1'b1;
    bank_n   = 5'd3;
    #1;
    step();                                          // T+1
    bank_vld = 1'b0;
    #1;
    for (int k = 2; k <= 12; k++) begin
      step();
      if (k == 3) begin
        chk("t4_out_vld_t3", 32'(out_vld), 32'd1);
        chk("t4_out_dat_t3", out_dat, 32'h50);
      end
    end
    chk("t4_rd_en_t12", 32'(rd_en), 32'd0);
    chk("t4_rd_cnt_t12", 32'(rd_cnt), 32'd2);
    chk("t4_dat_hold", out_dat, 32'h50);
    step();                                          // T+13
    out_rdy = 1'b1;
    #1;
    chk("t4_rd_en_pop", 32'(rd_en), 32'd1);
    chk("t4_rd_addr_pop", 32'(rd_addr), 32'd2);
    wait_done("t4_done", 10);
    step();
    chk("t4_pop_cnt", 32'(pop_dat.size()), 32'd3);
    if (pop_dat.size() == 3) begin
      chk("t4_pop0", pop_dat[0], 32'h50);
      chk("t4_pop1", pop_dat[1], 32'h60);
      chk("t4_pop2", pop_dat[2], 32'h80);
      chk("t4_last2", 32'(pop_last[2]), 32'd1);
    end

    // Reset in T+4 of an n=8 bank, then a fresh n=2 bank
    clear_logs();
    for (int i = 0; i < 8; i++) mem[i] = 32'h200 + 32'(i);
    bank_vld = 1'b1;
    bank_n   = 5'd8;
    #1;
    step();                                          // T+1
    bank_vld = 1'b0;
    step();                                          // T+2
    step();                                          // T+3
    step();                                          // T+4
    rst_n = 1'b0;
    #1;
    step();                                          // T+5
    rst_n = 1'b1;
    #1;
    chk_reset_outputs("t5");
    chk("t5_no_done", 32'(done_cnt), 32'd0);
    clear_logs();
    mem[0]   = 32'hAA;
    mem[1]   = 32'hBB;
    bank_vld = 1'b1;
    bank_n   = 5'd2;
    #1;
    step();
    bank_vld = 1'b0;
    #1;
    wait_done("t5_done", 12);
    step();
    chk("t5_pop_cnt", 32'(pop_dat.size()), 32'd2);
    if (pop_dat.size() == 2) begin
      chk("t5_pop0", pop_dat[0], 32'hAA);
      chk("t5_pop1", pop_dat[1], 32'hBB);
      chk("t5_last0", 32'(pop_last[0]), 32'd0);
      chk("t5_last1", 32'(pop_last[1]), 32'd1);
    end

    // bank_vld held across two back-to-back n=1 banks
    clear_logs();
    mem[0]   = 32'h11;
    bank_vld = 1'b1;
    bank_n   = 5'd1;
    #1;
    step();                                          // T+1
    chk("t6_rd_en_t1", 32'(rd_en), 32'd1);
    chk("t6_rdy_t1", 32'(bank_rdy), 32'd0);
    for (int k = 2; k <= 4; k++) begin
      step();
      chk("t6_rdy_low", 32'(bank_rdy), 32'd0);
      chk("t6_rd_en_low", 32'(rd_en), 32'd0);
    end
    chk("t6_done_t4", 32'(bank_done), 32'd1);
    step();                                          // T+5
    chk("t6_rdy_t5", 32'(bank_rdy), 32'd1);
    chk("t6_busy_t5", 32'(busy), 32'd0);
    mem[0] = 32'h22;
    step();                                          // T+6
    chk("t6_busy_t6", 32'(busy), 32'd1);
    chk("t6_rd_en_t6", 32'(rd_en), 32'd1);
    bank_vld = 1'b0;
    #1;
    wait_done("t6_done2", 10);
    step();
    chk("t6_done_cnt", 32'(done_cnt), 32'd2);
    chk("t6_pop_cnt", 32'(pop_dat.size()), 32'd2);
    if (pop_dat.size() == 2) begin
      chk("t6_pop0", pop_dat[0], 32'h11);
      chk("t6_pop1", pop_dat[1], 32'h22);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
